// File: rtl/pb_event_pkg.sv
// Shared definitions for the push-button gesture classifier and its consumers.
// Holds the classifier state encoding and the event bundle handed to the control FSM.
package pb_event_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRESS1 = 3'd1;
  localparam logic [STATE_W-1:0] ST_GAP    = 3'd2;
  localparam logic [STATE_W-1:0] ST_PRESS2 = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    PRESS1 = ST_PRESS1,
    GAP    = ST_GAP,
    PRESS2 = ST_PRESS2,
    HOLD   = ST_HOLD
  } pb_fsm_state_t;

  // One-cycle command pulses; at most one bit is set in any cycle.
  typedef struct packed {
    logic click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
  } pb_event_t;

endpackage

// File: rtl/event_timer.sv
// Shared gesture timer: up-counter with synchronous clear and enable, flagging
// when the count equals a threshold chosen by the FSM each cycle.
module event_timer #(
  parameter int CNT_WIDTH = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] threshold,
  output logic                 hit
);

  logic [CNT_WIDTH-1:0] cnt_reg;

  // Clear takes priority so a state change always restarts timing from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign hit = (cnt_reg == threshold);

endmodule

// File: rtl/pb_event_classifier.sv
// Turns the debounced button event stream into click / double-click / long-press
// and auto-repeat command pulses for the calculator control FSM.
module pb_event_classifier
  import pb_event_pkg::*;
#(
  parameter int CNT_WIDTH     = 27,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_state,
  input  logic pb_posedge,
  input  logic pb_negedge,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_TC    = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1);

  pb_fsm_state_t        state_reg, state_next;
  pb_event_t            evt_reg, evt_next;
  logic                 busy_reg;
  logic                 tmr_clear, tmr_en, tmr_hit, tmr_restart;
  logic [CNT_WIDTH-1:0] tmr_threshold;
  logic                 press, release_ev;

  // A simultaneous press and release counts only as a release; a low level while
  // pressed recovers a release whose negedge was lost.
  assign press      = pb_posedge & ~pb_negedge;
  assign release_ev = pb_negedge | ~pb_state;

  always_comb begin
    tmr_threshold = '0;
    case (state_reg)
      PRESS1:  tmr_threshold = LONG_TC;
      GAP:     tmr_threshold = GAP_TC;
      HOLD:    tmr_threshold = REPEAT_TC;
      default: tmr_threshold = '0;
    endcase
  end

  event_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (tmr_clear),
    .enable    (tmr_en),
    .threshold (tmr_threshold),
    .hit       (tmr_hit)
  );

  // Release/press checks come before the timer hit so they win on a shared edge.
  always_comb begin
    state_next  = state_reg;
    evt_next    = '0;
    tmr_en      = 1'b0;
    tmr_restart = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press) state_next = PRESS1;
      end
      PRESS1: begin
        tmr_en = 1'b1;
        if (release_ev) begin
          state_next = GAP;
        end else if (tmr_hit) begin
          state_next          = HOLD;
          evt_next.long_press = 1'b1;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        if (press) begin
          state_next = PRESS2;
        end else if (tmr_hit) begin
          state_next     = IDLE;
          evt_next.click = 1'b1;
        end
      end
      PRESS2: begin
        if (release_ev) begin
          state_next            = IDLE;
          evt_next.double_click = 1'b1;
        end
      end
      HOLD: begin
        tmr_en = 1'b1;
        if (release_ev) begin
          state_next = IDLE;
        end else if (tmr_hit) begin
          evt_next.repeat_pulse = 1'b1;
          tmr_restart           = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    tmr_clear = tmr_restart | (state_next != state_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      evt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      evt_reg   <= evt_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign click        = evt_reg.click;
  assign double_click = evt_reg.double_click;
  assign long_press   = evt_reg.long_press;
  assign repeat_pulse = evt_reg.repeat_pulse;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_pb_event_classifier.sv
// Scenario bench for pb_event_classifier: expected pulses are queued with their
// cycle when stimulus is driven and matched by a monitor as outputs appear.
module tb_pb_event_classifier;

  localparam int CW = 4;
  localparam int L  = 8;
  localparam int G  = 6;
  localparam int R  = 4;

  localparam int K_CLICK  = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_state = 1'b0;
  logic pb_posedge = 1'b0;
  logic pb_negedge = 1'b0;
  logic click, double_click, long_press, repeat_pulse, busy;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_edge = 0;

  pb_event_classifier #(
    .CNT_WIDTH     (CW),
    .LONG_CYCLES   (L),
    .GAP_CYCLES    (G),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pb_state     (pb_state),
    .pb_posedge   (pb_posedge),
    .pb_negedge   (pb_negedge),
    .click        (click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse seen must be the next queued expectation, on its cycle.
  always @(negedge clk) begin
    int   n_hi;
    int   kind;
    exp_t e;
    n_hi = int'(click) + int'(double_click) + int'(long_press) + int'(repeat_pulse);
    kind = click ? K_CLICK : double_click ? K_DOUBLE : long_press ? K_LONG : K_REPEAT;
    if (n_hi > 1) begin
      checks++;
      errors++;
      $display("FAIL pulse_exclusive cyc=%0d: %0d outputs high, required at most 1", cyc, n_hi);
    end else if (n_hi == 1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d: kind %0d seen, required none", cyc, kind);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc !== cyc || e.kind !== kind) begin
          errors++;
          $display("FAIL pulse_match: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                   kind, cyc, e.kind, e.cyc);
        end
      end
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse: kind %0d required at cyc %0d, not seen by cyc %0d",
               e.kind, e.cyc, cyc);
    end
  end

  task automatic drv(input logic p, input logic n, input logic s);
    @(negedge clk);
    pb_posedge = p;
    pb_negedge = n;
    pb_state   = s;
    last_edge  = cyc + 1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_pulse(input int at, input int kind);
    exp_t e;
    e.cyc  = at;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic pulse_rst(input logic keep_state);
    @(negedge clk);
    rst = 1'b1;
    pb_posedge = 1'b0;
    pb_negedge = 1'b0;
    pb_state   = keep_state;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({click, double_click, long_press, repeat_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000",
               {click, double_click, long_press, repeat_pulse});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_click;
    int er;
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    er = last_edge;
    expect_pulse(er + G, K_CLICK);
    idle(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL click_busy_gap: got %b, required 1", busy);
    end
    idle(G + 3);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL click_done: pending=%0d busy=%b, required pending=0 busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_double_click;
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    idle(1);
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    expect_pulse(last_edge, K_DOUBLE);
    idle(G + 4);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL double_done: pending=%0d busy=%b, required pending=0 busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_long_repeat;
    int e0;
    drv(1'b1, 1'b0, 1'b1);
    e0 = last_edge;
    expect_pulse(e0 + L, K_LONG);
    expect_pulse(e0 + L + R, K_REPEAT);
    expect_pulse(e0 + L + 2 * R, K_REPEAT);
    for (int i = 0; i < 19; i++) drv(1'b0, 1'b0, 1'b1);
    // Release lands on the third repeat boundary: no pulse expected.
    drv(1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL long_done: pending=%0d busy=%b, required pending=0 busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_boundaries;
    int er;
    drv(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < L - 1; i++) drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    expect_pulse(last_edge + G, K_CLICK);
    idle(G + 3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_edge_release: pending=%0d, required 0", exp_q.size());
    end
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    er = last_edge;
    idle(G - 1);
    drv(1'b1, 1'b0, 1'b1);
    checks++;
    if (last_edge !== er + G) begin
      errors++;
      $display("FAIL gap_edge_align: press edge %0d, required %0d", last_edge, er + G);
    end
    drv(1'b0, 1'b1, 1'b0);
    expect_pulse(last_edge, K_DOUBLE);
    idle(G + 3);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_edge_press: pending=%0d busy=%b, required pending=0 busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid;
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    idle(2);
    pulse_rst(1'b0);
    checks++;
    if ({click, double_click, long_press, repeat_pulse, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_gap: outputs+busy=%b, required 00000",
               {click, double_click, long_press, repeat_pulse, busy});
    end
    idle(G + 2);
    drv(1'b1, 1'b0, 1'b1);
    expect_pulse(last_edge + L, K_LONG);
    for (int i = 0; i < L + 1; i++) drv(1'b0, 1'b0, 1'b1);
    pulse_rst(1'b1);
    checks++;
    if ({click, double_click, long_press, repeat_pulse, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_hold: outputs+busy=%b, required 00000",
               {click, double_click, long_press, repeat_pulse, busy});
    end
    // Level still high but no fresh posedge: must stay idle.
    for (int i = 0; i < R + 2; i++) drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_fresh_press: busy=%b, required 0", busy);
    end
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b1, 1'b0);
    expect_pulse(last_edge + G, K_CLICK);
    idle(G + 3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_recover: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_missed_negedge;
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0);
    expect_pulse(last_edge + G, K_CLICK);
    idle(G + 3);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL missed_negedge: pending=%0d busy=%b, required pending=0 busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_both_edges;
    drv(1'b1, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL both_edges_idle: busy=%b, required 0", busy);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_click();
    test_double_click();
    test_long_repeat();
    test_boundaries();
    test_reset_mid();
    test_missed_negedge();
    test_both_edges();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
